// File: rtl/ram_pkg.sv
// Shared constants and helpers for the parametrised simple-dual-port RAM.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam logic [0:0] ST_CLR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  function automatic int nb_lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic bit lanes_fit(input int data_w, input int byte_w);
    return (byte_w > 0) && ((data_w % byte_w) == 0);
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array with byte-lane writes, the read-during-write policy and the
// first read register. rst_i is synchronous and active-low.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int BYTE_W   = 8,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_en_i,
  input  logic [ADDR_W-1:0]                   wr_adr_i,
  input  logic [DATA_W-1:0]                   wr_dat_i,
  input  logic [nb_lanes(DATA_W, BYTE_W)-1:0] wr_be_i,
  input  logic                                rd_en_i,
  input  logic [ADDR_W-1:0]                   rd_adr_i,
  output logic [DATA_W-1:0]                   rd_dat_o,
  output logic                                rd_vld_o
);

  localparam int NB    = nb_lanes(DATA_W, BYTE_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_dat_d, rd_dat_q;
  logic              rd_vld_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_i[i]) mem[wr_adr_i][i*BYTE_W +: BYTE_W] <= wr_dat_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Write-first forwards only the enabled lanes of a same-address write.
  always_comb begin
    rd_dat_d = mem[rd_adr_i];
    if ((RDW_MODE == RDW_WRITE_FIRST) && wr_en_i && (wr_adr_i == rd_adr_i)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_i[i]) rd_dat_d[i*BYTE_W +: BYTE_W] = wr_dat_i[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_i;
      if (rd_en_i) rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM: clear-on-reset sweep, ready gating,
// optional output register and read-valid strobe around ram_sdp_core.
//
// Handshake: a request (we or re) is taken at a rising edge only while
// rdy=1 and rst=1; each taken read yields exactly one rd_vld=1 cycle,
// 1+OUT_REG cycles later, in issue order. There is no backpressure.
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 4,
  parameter int                BYTE_W     = 8,
  parameter int                OUT_REG    = 0,
  parameter int                RDW_MODE   = RDW_READ_FIRST,
  parameter int                CLR_ON_RST = 0,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter                    INIT_FILE  = ""
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                rdy,
  input  logic                                we,
  input  logic [ADDR_W-1:0]                   wr_adr,
  input  logic [DATA_W-1:0]                   dat_w,
  input  logic [nb_lanes(DATA_W, BYTE_W)-1:0] be,
  input  logic                                re,
  input  logic [ADDR_W-1:0]                   rd_adr,
  output logic [DATA_W-1:0]                   dat_r,
  output logic                                rd_vld,
  output logic [0:0]                          dbg_state
);

  localparam int NB = nb_lanes(DATA_W, BYTE_W);

  if (!lanes_fit(DATA_W, BYTE_W)) begin : g_bad_lanes
    $error("ram_sdp_param: DATA_W must be a multiple of BYTE_W");
  end

  // Preloading from INIT_FILE is handed to the implementation flow's
  // memory-initialisation mechanism; without it contents start undefined.
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_adr_q, clr_adr_d;

  always_comb begin
    state_d   = state_q;
    clr_adr_d = clr_adr_q;
    if (state_q == ST_CLR) begin
      clr_adr_d = clr_adr_q + 1'b1;
      if (&clr_adr_q) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= (CLR_ON_RST != 0) ? ST_CLR : ST_RUN;
      clr_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_adr_q <= clr_adr_d;
    end
  end

  assign rdy       = (state_q == ST_RUN);
  assign dbg_state = state_q;

  // The sweep borrows the write port; user writes are ignored meanwhile.
  logic              core_we, core_re, core_vld;
  logic [ADDR_W-1:0] core_adr;
  logic [DATA_W-1:0] core_wdat, core_rdat;
  logic [NB-1:0]     core_be;

  always_comb begin
    core_we   = 1'b0;
    core_adr  = wr_adr;
    core_wdat = dat_w;
    core_be   = be;
    if (rst) begin
      if (state_q == ST_CLR) begin
        core_we   = 1'b1;
        core_adr  = clr_adr_q;
        core_wdat = CLR_VAL;
        core_be   = '1;
      end else begin
        core_we = we;
      end
    end
  end

  assign core_re = rst & rdy & re;

  ram_sdp_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BYTE_W  (BYTE_W),
    .RDW_MODE(RDW_MODE)
  ) u_core (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_en_i (core_we),
    .wr_adr_i(core_adr),
    .wr_dat_i(core_wdat),
    .wr_be_i (core_be),
    .rd_en_i (core_re),
    .rd_adr_i(rd_adr),
    .rd_dat_o(core_rdat),
    .rd_vld_o(core_vld)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] out_dat_q;
    logic              out_vld_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        out_dat_q <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= core_vld;
        if (core_vld) out_dat_q <= core_rdat;
      end
    end

    assign dat_r  = out_dat_q;
    assign rd_vld = out_vld_q;
  end else begin : g_no_out_reg
    assign dat_r  = core_rdat;
    assign rd_vld = core_vld;
  end

endmodule
